// File: rtl/mux_b_t_s_multi_if.sv
// Bus bundle for the temporal-to-spatial selector: candidate buses and temporal select
// come in on the slave side; the selected bus and status pulses go out.
interface mux_b_t_s_multi_if #(
    parameter int NUM_INPUTS = 16,
    parameter int BUS_WIDTH  = 8,
    parameter int CNT_W      = 5
);
    logic [NUM_INPUTS-1:0][BUS_WIDTH-1:0] inputs;
    logic                                 select_line;
    logic [BUS_WIDTH-1:0]                 y;
    logic                                 y_valid;
    logic [CNT_W-1:0]                     y_index;
    logic [CNT_W-1:0]                     gamma_idx;
    logic                                 no_event;
    logic                                 out_of_range;

    modport master (
        output inputs, select_line,
        input  y, y_valid, y_index, gamma_idx, no_event, out_of_range
    );

    modport slave (
        input  inputs, select_line,
        output y, y_valid, y_index, gamma_idx, no_event, out_of_range
    );
endinterface

// File: rtl/mux_b_t_s_multi.sv
// Race-logic temporal-to-spatial selector: decodes a rising/falling/pulse-width coded select
// per gamma cycle and latches inputs[index] onto y. MUX_BTS_HOLD_EN keeps y across idle cycles.
module mux_b_t_s_multi #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int NUM_INPUTS        = GAMMA_CYCLE_WIDTH,
    parameter int BUS_WIDTH         = 8,
    parameter int MODE              = 0,
    parameter int CNT_W             = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
    input  logic              aclk,
    input  logic              grst_n,
    mux_b_t_s_multi_if.slave  bus
);

    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(GAMMA_CYCLE_WIDTH);
    localparam logic [CNT_W-1:0] NIN_C  = CNT_W'(NUM_INPUTS);

    logic [CNT_W-1:0]     gamma_r;
    logic [CNT_W-1:0]     width_r;
    logic [CNT_W-1:0]     y_index_r;
    logic [BUS_WIDTH-1:0] y_r;
    logic                 sel_q_r;
    logic                 taken_r;
    logic                 y_valid_r;
    logic                 no_event_r;
    logic                 oor_r;

    logic                 wrap_s;
    logic                 prev_s;
    logic                 edge_s;
    logic                 accept_s;
    logic                 oor_s;
    logic                 miss_s;
    logic [CNT_W-1:0]     width_nxt_s;
    logic [CNT_W-1:0]     idx_s;
    logic [BUS_WIDTH-1:0] pick_s;

    // Edge detection and running pulse width for the current sample.
    always_comb begin
        wrap_s      = (gamma_r == LAST_C);
        prev_s      = sel_q_r;
        edge_s      = 1'b0;
        width_nxt_s = width_r;
        if (bus.select_line && (width_r < FULL_C)) begin
            width_nxt_s = width_r + ONE_C;
        end else begin
            width_nxt_s = width_r;
        end
        // Forcing prev at cycle start makes a level already asserted count as index 0.
        if (gamma_r == ZERO_C) begin
            prev_s = (MODE == 1) ? 1'b1 : 1'b0;
        end else begin
            prev_s = sel_q_r;
        end
        case (MODE)
            0:       edge_s = bus.select_line & ~prev_s;
            1:       edge_s = ~bus.select_line & prev_s;
            default: edge_s = 1'b0;
        endcase
    end

    // Decode the sample into an index and classify it as accepted, out of range or missed.
    always_comb begin
        accept_s = 1'b0;
        oor_s    = 1'b0;
        idx_s    = ZERO_C;
        if (MODE == 2) begin
            idx_s = width_nxt_s - ONE_C;
            if (wrap_s && (width_nxt_s != ZERO_C) && (width_nxt_s <= NIN_C)) begin
                accept_s = 1'b1;
            end else if (wrap_s && (width_nxt_s > NIN_C)) begin
                oor_s = 1'b1;
            end else begin
                accept_s = 1'b0;
            end
        end else begin
            idx_s = gamma_r;
            if (edge_s && !taken_r && (gamma_r < NIN_C)) begin
                accept_s = 1'b1;
            end else if (edge_s && !taken_r) begin
                oor_s = 1'b1;
            end else begin
                accept_s = 1'b0;
            end
        end
        miss_s = wrap_s && !taken_r && !accept_s;
    end

    // Select the candidate bus for the decoded index without out-of-bounds array reads.
    always_comb begin
        pick_s = {BUS_WIDTH{1'b0}};
        for (int i = 0; i < NUM_INPUTS; i++) begin
            pick_s = (idx_s == CNT_W'(i)) ? bus.inputs[i] : pick_s;
        end
    end

    // Gamma counter, per-cycle bookkeeping and registered outputs.
    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            gamma_r    <= ZERO_C;
            width_r    <= ZERO_C;
            y_index_r  <= ZERO_C;
            y_r        <= {BUS_WIDTH{1'b0}};
            sel_q_r    <= 1'b0;
            taken_r    <= 1'b0;
            y_valid_r  <= 1'b0;
            no_event_r <= 1'b0;
            oor_r      <= 1'b0;
        end else begin
            gamma_r    <= wrap_s ? ZERO_C : (gamma_r + ONE_C);
            width_r    <= wrap_s ? ZERO_C : width_nxt_s;
            taken_r    <= wrap_s ? 1'b0 : (taken_r | accept_s);
            sel_q_r    <= bus.select_line;
            y_valid_r  <= accept_s;
            no_event_r <= miss_s;
            oor_r      <= oor_s;
            if (accept_s) begin
                y_r       <= pick_s;
                y_index_r <= idx_s;
`ifdef MUX_BTS_HOLD_EN
            end else begin
                y_r       <= y_r;
                y_index_r <= y_index_r;
            end
`else
            end else if (miss_s) begin
                y_r       <= {BUS_WIDTH{1'b0}};
                y_index_r <= ZERO_C;
            end else begin
                y_r       <= y_r;
                y_index_r <= y_index_r;
            end
`endif
        end
    end

    assign bus.y            = y_r;
    assign bus.y_valid      = y_valid_r;
    assign bus.y_index      = y_index_r;
    assign bus.gamma_idx    = gamma_r;
    assign bus.no_event     = no_event_r;
    assign bus.out_of_range = oor_r;

endmodule

// File: tb/tb_mux_b_t_s_multi.sv
// Directed bench for mux_b_t_s_multi: rising, falling, pulse-width and a 10-input rising
// instance share one clock; each table row is one full gamma cycle on one instance.
module tb_mux_b_t_s_multi;

    logic aclk = 1'b0;
    logic grst_n = 1'b0;
    always #5 aclk = ~aclk;

    mux_b_t_s_multi_if #(.NUM_INPUTS(16), .BUS_WIDTH(8), .CNT_W(5)) if_rise ();
    mux_b_t_s_multi_if #(.NUM_INPUTS(16), .BUS_WIDTH(8), .CNT_W(5)) if_fall ();
    mux_b_t_s_multi_if #(.NUM_INPUTS(16), .BUS_WIDTH(8), .CNT_W(5)) if_pulse ();
    mux_b_t_s_multi_if #(.NUM_INPUTS(10), .BUS_WIDTH(8), .CNT_W(5)) if_r10 ();

    mux_b_t_s_multi #(.GAMMA_CYCLE_WIDTH(16), .NUM_INPUTS(16), .BUS_WIDTH(8), .MODE(0))
        u_rise (.aclk(aclk), .grst_n(grst_n), .bus(if_rise.slave));
    mux_b_t_s_multi #(.GAMMA_CYCLE_WIDTH(16), .NUM_INPUTS(16), .BUS_WIDTH(8), .MODE(1))
        u_fall (.aclk(aclk), .grst_n(grst_n), .bus(if_fall.slave));
    mux_b_t_s_multi #(.GAMMA_CYCLE_WIDTH(16), .NUM_INPUTS(16), .BUS_WIDTH(8), .MODE(2))
        u_pulse (.aclk(aclk), .grst_n(grst_n), .bus(if_pulse.slave));
    mux_b_t_s_multi #(.GAMMA_CYCLE_WIDTH(16), .NUM_INPUTS(10), .BUS_WIDTH(8), .MODE(0))
        u_r10 (.aclk(aclk), .grst_n(grst_n), .bus(if_r10.slave));

    logic       sel_a   [4];
    logic [7:0] y_a     [4];
    logic       valid_a [4];
    logic [4:0] idx_a   [4];
    logic [4:0] gamma_a [4];
    logic       ne_a    [4];
    logic       oor_a   [4];

    assign if_rise.select_line  = sel_a[0];
    assign if_fall.select_line  = sel_a[1];
    assign if_pulse.select_line = sel_a[2];
    assign if_r10.select_line   = sel_a[3];

    assign y_a[0] = if_rise.y;   assign y_a[1] = if_fall.y;
    assign y_a[2] = if_pulse.y;  assign y_a[3] = if_r10.y;
    assign valid_a[0] = if_rise.y_valid;   assign valid_a[1] = if_fall.y_valid;
    assign valid_a[2] = if_pulse.y_valid;  assign valid_a[3] = if_r10.y_valid;
    assign idx_a[0] = if_rise.y_index;   assign idx_a[1] = if_fall.y_index;
    assign idx_a[2] = if_pulse.y_index;  assign idx_a[3] = if_r10.y_index;
    assign gamma_a[0] = if_rise.gamma_idx;   assign gamma_a[1] = if_fall.gamma_idx;
    assign gamma_a[2] = if_pulse.gamma_idx;  assign gamma_a[3] = if_r10.gamma_idx;
    assign ne_a[0] = if_rise.no_event;   assign ne_a[1] = if_fall.no_event;
    assign ne_a[2] = if_pulse.no_event;  assign ne_a[3] = if_r10.no_event;
    assign oor_a[0] = if_rise.out_of_range;   assign oor_a[1] = if_fall.out_of_range;
    assign oor_a[2] = if_pulse.out_of_range;  assign oor_a[3] = if_r10.out_of_range;

    typedef struct {
        int         dut;
        logic [15:0] pat;
        int         v_at;
        int         oor_at;
        logic       ne;
        logic [7:0] y_end;
        logic [4:0] idx_end;
    } vec_t;

    vec_t tbl [15];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [7:0] miss_y(input logic [7:0] prev);
`ifdef MUX_BTS_HOLD_EN
        return prev;
`else
        return 8'h00 & prev;
`endif
    endfunction

    function automatic logic [4:0] miss_i(input logic [4:0] prev);
`ifdef MUX_BTS_HOLD_EN
        return prev;
`else
        return 5'd0 & prev;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_sel();
        sel_a[0] = 1'b0;
        sel_a[1] = 1'b1;
        sel_a[2] = 1'b0;
        sel_a[3] = 1'b0;
    endtask

    task automatic apply(input int row, input vec_t v);
        string tag;
        for (int g = 0; g < 16; g++) begin
            idle_sel();
            sel_a[v.dut] = v.pat[g];
            step();
            tag = $sformatf("row%0d dut%0d g%0d", row, v.dut, g);
            chk({tag, " gamma_idx"}, 32'(gamma_a[v.dut]), 32'((g + 1) % 16));
            chk({tag, " y_valid"}, 32'(valid_a[v.dut]), 32'(g == v.v_at));
            chk({tag, " no_event"}, 32'(ne_a[v.dut]), 32'((g == 15) && v.ne));
            chk({tag, " out_of_range"}, 32'(oor_a[v.dut]), 32'(g == v.oor_at));
            if (g == v.v_at) begin
                chk({tag, " y@valid"}, 32'(y_a[v.dut]), 32'(v.y_end));
                chk({tag, " y_index@valid"}, 32'(idx_a[v.dut]), 32'(v.idx_end));
            end
        end
        chk($sformatf("row%0d y_end", row), 32'(y_a[v.dut]), 32'(v.y_end));
        chk($sformatf("row%0d y_index_end", row), 32'(idx_a[v.dut]), 32'(v.idx_end));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            if_rise.inputs[i]  = 8'hA0 + 8'(i);
            if_fall.inputs[i]  = 8'hA0 + 8'(i);
            if_pulse.inputs[i] = 8'hA0 + 8'(i);
        end
        for (int i = 0; i < 10; i++) begin
            if_r10.inputs[i] = 8'hA0 + 8'(i);
        end
        idle_sel();

        // dut, pattern (bit g = select while gamma_idx==g), valid at, oor at, no_event, y, y_index
        tbl[0]  = '{0, 16'h0660,  5, -1, 1'b0, 8'hA5, 5'd5};
        tbl[1]  = '{0, 16'h0000, -1, -1, 1'b1, miss_y(8'hA5), miss_i(5'd5)};
        tbl[2]  = '{0, 16'hFFFF,  0, -1, 1'b0, 8'hA0, 5'd0};
        tbl[3]  = '{0, 16'h8000, 15, -1, 1'b0, 8'hAF, 5'd15};
        tbl[4]  = '{1, 16'h0FFF, 12, -1, 1'b0, 8'hAC, 5'd12};
        tbl[5]  = '{1, 16'h0000,  0, -1, 1'b0, 8'hA0, 5'd0};
        tbl[6]  = '{1, 16'hFFFF, -1, -1, 1'b1, miss_y(8'hA0), miss_i(5'd0)};
        tbl[7]  = '{2, 16'h0078, 15, -1, 1'b0, 8'hA3, 5'd3};
        tbl[8]  = '{2, 16'hFFFF, 15, -1, 1'b0, 8'hAF, 5'd15};
        tbl[9]  = '{2, 16'h0106, 15, -1, 1'b0, 8'hA2, 5'd2};
        tbl[10] = '{2, 16'h0000, -1, -1, 1'b1, miss_y(8'hA2), miss_i(5'd2)};
        tbl[11] = '{3, 16'h1000, -1, 12, 1'b1, 8'h00, 5'd0};
        tbl[12] = '{3, 16'h1008,  3, -1, 1'b0, 8'hA3, 5'd3};
        tbl[13] = '{3, 16'h0200,  9, -1, 1'b0, 8'hA9, 5'd9};
        tbl[14] = '{3, 16'h0400, -1, 10, 1'b1, miss_y(8'hA9), miss_i(5'd9)};

        // Reset values on every instance.
        step();
        step();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset dut%0d y", d), 32'(y_a[d]), 32'd0);
            chk($sformatf("reset dut%0d y_valid", d), 32'(valid_a[d]), 32'd0);
            chk($sformatf("reset dut%0d y_index", d), 32'(idx_a[d]), 32'd0);
            chk($sformatf("reset dut%0d gamma_idx", d), 32'(gamma_a[d]), 32'd0);
            chk($sformatf("reset dut%0d no_event", d), 32'(ne_a[d]), 32'd0);
            chk($sformatf("reset dut%0d out_of_range", d), 32'(oor_a[d]), 32'd0);
        end
        grst_n = 1'b1;

        for (int r = 0; r < 15; r++) begin
            apply(r, tbl[r]);
        end

        // Asynchronous reset mid-cycle after an accepted event, then a clean restart.
        idle_sel();
        sel_a[0] = 1'b1;
        for (int g = 0; g < 7; g++) begin
            step();
        end
        chk("pre-reset gamma_idx", 32'(gamma_a[0]), 32'd7);
        chk("pre-reset y", 32'(y_a[0]), 32'hA0);
        #2;
        grst_n = 1'b0;
        #1;
        chk("async reset y", 32'(y_a[0]), 32'd0);
        chk("async reset y_index", 32'(idx_a[0]), 32'd0);
        chk("async reset gamma_idx", 32'(gamma_a[0]), 32'd0);
        chk("async reset y_valid", 32'(valid_a[0]), 32'd0);
        sel_a[0] = 1'b0;
        step();
        step();
        grst_n = 1'b1;
        for (int g = 0; g < 15; g++) begin
            step();
            chk($sformatf("restart g%0d gamma_idx", g), 32'(gamma_a[0]), 32'(g + 1));
            chk($sformatf("restart g%0d no_event", g), 32'(ne_a[0]), 32'd0);
            chk($sformatf("restart g%0d y_valid", g), 32'(valid_a[0]), 32'd0);
        end
        step();
        chk("restart wrap no_event", 32'(ne_a[0]), 32'd1);
        chk("restart wrap gamma_idx", 32'(gamma_a[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
